// File: rtl/pc_sequencer.sv
// Program-counter owner: computes the next PC from the jump/branch select,
// writes link addresses and runs the memory-indirect jump read with timeout.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic [1:0]  cont,
  input  logic        link,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  input  logic [31:0] rs_val,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        link_we,
  output logic [31:0] link_data,
  output logic        bus_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  // Handshake: mem_req is held high with a stable mem_addr for the whole
  // MEM_WAIT stay; a read completes on any edge where mem_ack is high, and
  // mem_rdata is taken from that same cycle.

  state_t        state, state_n;
  logic [31:0]   pc_n, mem_addr_n, link_data_n, p4_lat, p4_lat_n;
  logic          link_lat, link_lat_n, link_we_n, bus_err_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   p4, br_off;

  assign p4     = pc + 32'd4;
  assign br_off = {{14{imm[15]}}, imm, 2'b00};

  // Both strobes derive from the state register only.
  assign stall   = (state == MEM_WAIT);
  assign mem_req = (state == MEM_WAIT);

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    mem_addr_n  = mem_addr;
    link_data_n = link_data;
    p4_lat_n    = p4_lat;
    link_lat_n  = link_lat;
    cnt_n       = cnt;
    link_we_n   = 1'b0;
    bus_err_n   = 1'b0;
    case (state)
      RUN: begin
        if (step) begin
          case (cont)
            2'b00: begin
              mem_addr_n = rs_val;
              link_lat_n = link;
              p4_lat_n   = p4;
              cnt_n      = '0;
              state_n    = MEM_WAIT;
            end
            2'b01:   pc_n = p4 + br_off;
            2'b10:   pc_n = p4;
            default: pc_n = {p4[31:28], target, 2'b00};
          endcase
          if (cont != 2'b00 && link) begin
            link_we_n   = 1'b1;
            link_data_n = p4;
          end
        end
      end
      MEM_WAIT: begin
        // Ack takes priority over a coincident timeout.
        if (mem_ack) begin
          pc_n    = mem_rdata & 32'hFFFF_FFFC;
          state_n = RUN;
          if (link_lat) begin
            link_we_n   = 1'b1;
            link_data_n = p4_lat;
          end
        end else if (cnt == CNT_LAST) begin
          pc_n      = p4_lat;
          bus_err_n = 1'b1;
          state_n   = RUN;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      pc        <= RESET_PC;
      mem_addr  <= '0;
      link_data <= '0;
      p4_lat    <= '0;
      link_lat  <= 1'b0;
      cnt       <= '0;
      link_we   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      mem_addr  <= mem_addr_n;
      link_data <= link_data_n;
      p4_lat    <= p4_lat_n;
      link_lat  <= link_lat_n;
      cnt       <= cnt_n;
      link_we   <= link_we_n;
      bus_err   <= bus_err_n;
    end
  end

endmodule
